// File: rtl/enc_prio_param.sv
//------------------------------------------------------------------------------
// enc_prio_param
//
// Registered N-to-log2(N) priority encoder with a valid/ready handshake on
// both sides. The grant is the highest set index (RR=0) or the first set bit
// found searching upward from a rotating pointer (RR=1). Zero and multi-hot
// request vectors are flagged on the output alongside the encoded result.
//
// Parameters
//   N      number of request lines (2..256)
//   RR     0 = fixed priority (highest index wins), 1 = round-robin
//   IDX_W  width of the encoded index, derived from N; leave at default
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_req      request vector, any number of bits may be set
//   in_valid    in_req is valid this cycle
//   in_ready    input side may accept (combinational from output state)
//   out_idx     encoded index of the granted request
//   out_onehot  one-hot form of the grant, zero when out_none is set
//   out_none    captured vector was all zeros
//   out_multi   captured vector had two or more bits set
//   out_valid   output register holds a result
//   out_ready   consumer takes the result this cycle
//------------------------------------------------------------------------------
module enc_prio_param #(
    parameter int N     = 8,
    parameter int RR    = 0,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_req,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             out_none,
    output logic             out_multi,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [N-1:0]     ONE_N    = N'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [IDX_W-1:0] r_outIdx;
    logic [N-1:0]     r_outOnehot;
    logic             r_outNone;
    logic             r_outMulti;
    logic             r_outValid;
    logic [IDX_W-1:0] r_ptr;

    logic             w_accept;
    logic             w_none;
    logic             w_multi;
    logic [IDX_W-1:0] w_fixedIdx;
    logic [IDX_W-1:0] w_rrIdx;
    logic             w_rrFound;
    logic [IDX_W-1:0] w_grantIdx;
    logic [N-1:0]     w_onehot;

    // The input side is free whenever the output register is empty or is
    // being drained on this edge, which is what gives full throughput.
    assign in_ready = !r_outValid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Clearing the lowest set bit leaves something behind only when at least
    // two bits were set, so this gives popcount >= 2 without an adder tree.
    assign w_none  = ~|in_req;
    assign w_multi = |(in_req & (in_req - ONE_N));

    // Fixed priority: later iterations overwrite earlier ones, so the highest
    // set index wins. An all-zero vector leaves the default of 0.
    always_comb begin
        w_fixedIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (in_req[i]) begin
                w_fixedIdx = IDX_W'(i);
            end
        end
    end

    // Round-robin: walk N positions starting at the pointer. The wrap back to
    // zero is done by subtracting N so that non-power-of-two widths never
    // land on an index that does not exist. The sum is kept in an int so it
    // cannot overflow for N=256.
    always_comb begin
        int               posSum;
        logic [IDX_W-1:0] posIdx;
        posSum    = 0;
        posIdx    = '0;
        w_rrIdx   = '0;
        w_rrFound = 1'b0;
        for (int k = 0; k < N; k++) begin
            posSum = int'(r_ptr) + k;
            if (posSum >= N) begin
                posSum = posSum - N;
            end
            posIdx = IDX_W'(posSum);
            if (!w_rrFound && in_req[posIdx]) begin
                w_rrFound = 1'b1;
                w_rrIdx   = posIdx;
            end
        end
    end

    // Both searches default to 0 on an empty vector, so the grant index is
    // already 0 there and only the one-hot form needs an explicit mask.
    always_comb begin
        w_grantIdx = (RR != 0) ? w_rrIdx : w_fixedIdx;
        w_onehot   = w_none ? '0 : (ONE_N << w_grantIdx);
    end

    // Output register. A new result loads whenever the input is accepted,
    // which also covers the drain-and-refill case on the same edge. With no
    // accept, a taken result simply empties the register; the data fields
    // keep their stale contents since nobody looks at them while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_outIdx    <= '0;
            r_outOnehot <= '0;
            r_outNone   <= 1'b0;
            r_outMulti  <= 1'b0;
        end else if (w_accept) begin
            r_outValid  <= 1'b1;
            r_outIdx    <= w_grantIdx;
            r_outOnehot <= w_onehot;
            r_outNone   <= w_none;
            r_outMulti  <= w_multi;
        end else if (out_ready) begin
            r_outValid  <= 1'b0;
        end
    end

    // The fairness pointer only exists in round-robin mode. It moves one past
    // the winner on every accepted non-empty vector and wraps explicitly from
    // the last line back to zero; an empty vector leaves it where it was.
    generate
        if (RR != 0) begin : g_rrPtr
            logic [IDX_W-1:0] w_nextPtr;

            assign w_nextPtr = (w_grantIdx == LAST_IDX) ? '0 : (w_grantIdx + 1'b1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else if (w_accept && !w_none) begin
                    r_ptr <= w_nextPtr;
                end
            end
        end else begin : g_noPtr
            assign r_ptr = '0;
        end
    endgenerate

    assign out_idx    = r_outIdx;
    assign out_onehot = r_outOnehot;
    assign out_none   = r_outNone;
    assign out_multi  = r_outMulti;
    assign out_valid  = r_outValid;

endmodule
